// File: rtl/load_store_unit.sv
//==============================================================================
// Module      : load_store_unit
// Description : Single-outstanding load/store unit bridging the execute stage
//               to a request/grant/rvalid memory bus.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module load_store_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [1:0]            mem_size,
    input  logic                  mem_unsigned,
    input  logic [31:0]           addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [4:0]            rd,
    input  logic                  flush,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [31:0]           bus_addr,
    output logic [3:0]            bus_be,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_gnt,
    input  logic                  bus_rvalid,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic [4:0]            resp_rd,
    output logic                  resp_is_load
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t                  r_state;
    logic [1:0]              r_size;
    logic [1:0]              r_lane;
    logic                    r_unsigned;
    logic                    r_is_load;
    logic                    r_resp_valid;

    logic                    w_accept;
    logic                    w_err;
    logic [3:0]              w_be;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [DATA_WIDTH-1:0]   w_load_data;

    assign req_ready  = (r_state == S_IDLE);
    // A flush in the response cycle kills the already-registered pulse.
    assign resp_valid = r_resp_valid & ~flush;

    assign w_accept = req_valid & (mem_read | mem_write) & ~flush & (r_state == S_IDLE);
    assign w_err    = (mem_read & mem_write)
                    | ((mem_size == 2'b01) & addr[0])
                    | (mem_size[1] & (addr[1:0] != 2'b00));

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = wdata;
        case (mem_size)
            2'b00: begin
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << {addr[1], 1'b0};
                w_wdata = {2{wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = wdata;
            end
        endcase
    end

    always_comb begin
        w_byte = bus_rdata[7:0];
        case (r_lane)
            2'd0:    w_byte = bus_rdata[7:0];
            2'd1:    w_byte = bus_rdata[15:8];
            2'd2:    w_byte = bus_rdata[23:16];
            default: w_byte = bus_rdata[31:24];
        endcase
        w_half = r_lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (r_size)
            2'b00:   w_load_data = {{24{~r_unsigned & w_byte[7]}}, w_byte};
            2'b01:   w_load_data = {{16{~r_unsigned & w_half[15]}}, w_half};
            default: w_load_data = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_size       <= 2'b00;
            r_lane       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_is_load    <= 1'b0;
            r_resp_valid <= 1'b0;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_be       <= 4'b0000;
            bus_addr     <= 32'd0;
            bus_wdata    <= '0;
            resp_err     <= 1'b0;
            resp_data    <= '0;
            resp_rd      <= 5'd0;
            resp_is_load <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_size     <= mem_size;
                        r_lane     <= addr[1:0];
                        r_unsigned <= mem_unsigned;
                        r_is_load  <= mem_read;
                        resp_rd    <= rd;
                        if (w_err) begin
                            resp_err     <= 1'b1;
                            resp_data    <= '0;
                            resp_is_load <= 1'b0;
                            r_resp_valid <= 1'b1;
                            r_state      <= S_RESP;
                        end else begin
                            bus_req   <= 1'b1;
                            bus_we    <= mem_write;
                            bus_be    <= w_be;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_wdata <= w_wdata;
                            r_state   <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (bus_gnt || flush) begin
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        bus_be  <= 4'b0000;
                    end
                    // A granted access has been issued even if flushed: a load
                    // must still swallow its read data.
                    if (bus_gnt) begin
                        if (r_is_load) begin
                            r_state <= flush ? S_DRAIN : S_WAIT;
                        end else if (flush) begin
                            r_state <= S_IDLE;
                        end else begin
                            resp_err     <= 1'b0;
                            resp_data    <= '0;
                            resp_is_load <= 1'b0;
                            r_resp_valid <= 1'b1;
                            r_state      <= S_RESP;
                        end
                    end else if (flush) begin
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    // Data arriving with the flush is the data DRAIN would wait for.
                    if (bus_rvalid) begin
                        if (flush) begin
                            r_state <= S_IDLE;
                        end else begin
                            resp_err     <= 1'b0;
                            resp_data    <= w_load_data;
                            resp_is_load <= 1'b1;
                            r_resp_valid <= 1'b1;
                            r_state      <= S_RESP;
                        end
                    end else if (flush) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (bus_rvalid) begin
                        r_state <= S_IDLE;
                    end
                end
                S_RESP: begin
                    r_resp_valid <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
//==============================================================================
// Module      : tb_load_store_unit
// Description : Scoreboard bench for load_store_unit with a reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [1:0]  mem_size = 2'b00;
    logic        mem_unsigned = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [4:0]  rd = 5'd0;
    logic        flush = 1'b0;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt = 1'b0;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = 32'd0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_is_load;

    load_store_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .addr(addr), .wdata(wdata), .rd(rd),
        .flush(flush), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .resp_valid(resp_valid),
        .resp_err(resp_err), .resp_data(resp_data), .resp_rd(resp_rd),
        .resp_is_load(resp_is_load)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          err;
        logic [31:0] data;
        logic [4:0]  rd;
        bit          is_load;
    } resp_t;

    resp_t sb[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    last_resp_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every response pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (resp_valid) begin
            last_resp_cyc = cyc;
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_resp: got err=%b data=%h rd=%0d, required no response",
                         resp_err, resp_data, resp_rd);
            end else begin
                resp_t e;
                e = sb.pop_front();
                if ({resp_err, resp_data, resp_rd, resp_is_load} !== {e.err, e.data, e.rd, e.is_load}) begin
                    n_err++;
                    $display("FAIL resp: got err=%b data=%h rd=%0d load=%b, required err=%b data=%h rd=%0d load=%b",
                             resp_err, resp_data, resp_rd, resp_is_load, e.err, e.data, e.rd, e.is_load);
                end
            end
        end
        if (!bus_req) chk("bus_idle_we_be", {27'd0, bus_we, bus_be}, 32'd0);
    end

    function automatic bit model_err(bit r, bit w, logic [1:0] sz, logic [31:0] a);
        int off;
        off = int'(a[1:0]);
        if (r && w) return 1'b1;
        if (sz == 2'd1) return (off % 2) != 0;
        if (sz >= 2'd2) return off != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(logic [1:0] sz, bit uns, logic [31:0] a, logic [31:0] rdat);
        int unsigned v;
        int          off;
        off = int'(a[1:0]);
        if (sz == 2'd0) begin
            v = (rdat >> (8 * off)) & 32'hFF;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (rdat >> (8 * off)) & 32'hFFFF;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rdat;
        end
        return v;
    endfunction

    function automatic logic [3:0] model_be(logic [1:0] sz, logic [31:0] a);
        int off;
        off = int'(a[1:0]);
        if (sz == 2'd0) return 4'(1 << off);
        if (sz == 2'd1) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(logic [1:0] sz, logic [31:0] wd);
        if (sz == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // fl: 0 none, 1 flush in WAIT (load), 2 flush in REQ before grant, 3 flush with grant
    task automatic run_txn(input bit rf, input bit wf, input logic [1:0] sz, input bit uns,
                           input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rdi,
                           input int gd, input int rvd, input logic [31:0] rdat, input int fl);
        bit    e;
        bit    expect_resp;
        int    t0;
        int    exp_cyc;
        int    k;
        resp_t x;
        e = model_err(rf, wf, sz, a);
        chk("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; mem_read = rf; mem_write = wf; mem_size = sz;
        mem_unsigned = uns; addr = a; wdata = wd; rd = rdi;
        t0 = cyc;
        last_resp_cyc = -1;
        expect_resp = 1'b1;
        exp_cyc = 0;
        x.rd = rdi;
        if (e) begin
            x.err = 1'b1; x.data = 32'd0; x.is_load = 1'b0; exp_cyc = t0 + 1;
        end else if (fl == 0 && wf) begin
            x.err = 1'b0; x.data = 32'd0; x.is_load = 1'b0; exp_cyc = t0 + 2 + gd;
        end else if (fl == 0) begin
            x.err = 1'b0; x.data = model_load(sz, uns, a, rdat); x.is_load = 1'b1;
            exp_cyc = t0 + 3 + gd + rvd;
        end else begin
            expect_resp = 1'b0;
        end
        if (expect_resp) sb.push_back(x);
        tick();
        req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        addr = $urandom; wdata = $urandom; mem_size = 2'($urandom);
        if (e) begin
            @(negedge clk);
            chk("err_no_bus_req", {31'd0, bus_req}, 32'd0);
            tick();
        end else if (fl == 2) begin
            flush = 1'b1;
            @(negedge clk);
            chk("bus_req_before_flush", {31'd0, bus_req}, 32'd1);
            tick();
            flush = 1'b0;
            bus_rvalid = 1'b1;
            @(negedge clk);
            chk("flush_req_drop", {30'd0, bus_req, req_ready}, 32'd1);
            tick();
            bus_rvalid = 1'b0;
        end else begin
            for (k = 0; k <= gd; k++) begin
                if (k == gd) begin
                    bus_gnt = 1'b1;
                    if (fl == 3) flush = 1'b1;
                end
                @(negedge clk);
                chk("bus_req", {31'd0, bus_req}, 32'd1);
                chk("bus_we", {31'd0, bus_we}, {31'd0, wf});
                chk("bus_addr", bus_addr, {a[31:2], 2'b00});
                chk("bus_be", {28'd0, bus_be}, {28'd0, model_be(sz, a)});
                if (wf) chk("bus_wdata", bus_wdata, model_wdata(sz, wd));
                tick();
                bus_gnt = 1'b0;
                flush = 1'b0;
            end
            if (rf) begin
                if (fl == 1) begin
                    flush = 1'b1;
                    tick();
                    flush = 1'b0;
                end
                for (k = 0; k < rvd; k++) tick();
                bus_rvalid = 1'b1;
                bus_rdata = rdat;
                tick();
                bus_rvalid = 1'b0;
                bus_rdata = $urandom;
                if (fl != 0) chk("ready_after_drain", {31'd0, req_ready}, 32'd1);
            end else if (fl == 3) begin
                chk("store_flush_gnt_idle", {31'd0, req_ready}, 32'd1);
            end
        end
        for (k = 0; k < 10 && !req_ready; k++) tick();
        if (!req_ready) begin
            n_vec++; n_err++;
            $display("FAIL ready_timeout: got req_ready=0, required 1 within 10 cycles");
        end
        if (expect_resp) chk("resp_latency", 32'(last_resp_cyc), 32'(exp_cyc));
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion, required finish before 300us");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        bit          rf, wf;
        logic [1:0]  sz;
        int          op, fl, r;

        #2;
        chk("reset_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_bus", {bus_req, bus_we, bus_be, 26'd0}, 32'd0);
        chk("reset_bus_addr", bus_addr, 32'd0);
        chk("reset_bus_wdata", bus_wdata, 32'd0);
        chk("reset_resp", {resp_valid, resp_err, resp_is_load, resp_rd, 24'd0}, 32'd0);
        chk("reset_resp_data", resp_data, 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        run_txn(1, 0, 2'd0, 0, 32'h0000_1003, 32'd0, 5'd3, 0, 0, 32'h80FF_FF00, 0);
        run_txn(1, 0, 2'd1, 1, 32'h0000_2002, 32'd0, 5'd4, 0, 0, 32'hBEEF_1234, 0);
        run_txn(0, 1, 2'd0, 0, 32'h0000_3001, 32'h0000_00AB, 5'd5, 3, 0, 32'd0, 0);
        run_txn(1, 0, 2'd2, 0, 32'h0000_4002, 32'd0, 5'd6, 0, 0, 32'd0, 0);
        run_txn(1, 0, 2'd2, 0, 32'h0000_5000, 32'd0, 5'd7, 0, 1, 32'h1234_5678, 1);

        // Request with neither flag set and stray handshakes while idle.
        req_valid = 1'b1; bus_gnt = 1'b1; bus_rvalid = 1'b1;
        tick(); tick();
        req_valid = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
        chk("noflag_ready", {30'd0, bus_req, req_ready}, 32'd1);

        // Reset while a load waits for grant.
        req_valid = 1'b1; mem_read = 1'b1; mem_size = 2'd2; addr = 32'h0000_6000; rd = 5'd9;
        tick();
        req_valid = 1'b0; mem_read = 1'b0;
        chk("pre_reset_bus_req", {31'd0, bus_req}, 32'd1);
        rst = 1'b1;
        #1;
        chk("reset_mid_bus_req", {31'd0, bus_req}, 32'd0);
        chk("reset_mid_ready", {31'd0, req_ready}, 32'd1);
        tick();
        rst = 1'b0;
        bus_rvalid = 1'b1;
        tick();
        bus_rvalid = 1'b0;
        run_txn(1, 0, 2'd2, 0, 32'h0000_6000, 32'd0, 5'd9, 0, 0, 32'hCAFE_F00D, 0);

        for (int i = 0; i < 160; i++) begin
            op = int'($urandom_range(0, 7));
            rf = (op <= 3) || (op == 7);
            wf = (op >= 4);
            sz = 2'($urandom_range(0, 2));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            if ($urandom_range(0, 15) == 0) begin
                sz = 2'd3;
                a[0] = 1'b1;
            end
            r  = int'($urandom_range(0, 9));
            fl = (r == 0) ? 2 : (r == 1) ? 3 : (r == 2 && rf && !wf) ? 1 : 0;
            run_txn(rf, wf, sz, 1'($urandom), a, $urandom, 5'($urandom),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), $urandom, fl);
        end

        tick(); tick();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
